// File: rtl/histogram_pkg.sv
// Shared constants for the 256-bin histogram scratch layout and readout FSM.
// Word k of scratch holds bins 4k..4k+3; bin 4k+0 sits in the top lane.
package histogram_pkg;

    localparam int NUM_WORDS     = 64;
    localparam int BINS_PER_WORD = 4;
    localparam int BIN_W         = 32;
    localparam int WORD_W        = BINS_PER_WORD * BIN_W;

    // Lane bit positions inside a 128-bit scratch word
    localparam int LANE0_LSB = 96;
    localparam int LANE1_LSB = 64;
    localparam int LANE2_LSB = 32;
    localparam int LANE3_LSB = 0;

    // LSB of a lane for an arbitrary bin width; lane 0 is the most significant
    function automatic int lane_lsb(input int lane, input int bin_w);
        return (BINS_PER_WORD - 1 - lane) * bin_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/histogram_prefix_adder.sv
// Combinational running sum across the lanes of one scratch word.
// Wraps modulo 2^BIN_W; no saturation.
module histogram_prefix_adder #(
    parameter int NUM_LANES = 4,
    parameter int BIN_W     = 32
) (
    input  logic [BIN_W-1:0]                acc,
    input  logic [NUM_LANES-1:0][BIN_W-1:0] lane_bins,
    output logic [NUM_LANES-1:0][BIN_W-1:0] cum_bins,
    output logic [BIN_W-1:0]                acc_next
);

    // Chain lane 0 -> lane N-1 starting from the carried-in accumulator
    always_comb begin
        logic [BIN_W-1:0] run;
        cum_bins = '0;
        run      = acc;
        for (int j = 0; j < NUM_LANES; j++) begin
            run         = run + lane_bins[j];
            cum_bins[j] = run;
        end
        acc_next = run;
    end

endmodule

// File: rtl/histogram_readout.sv
// Streams the 256-bin histogram out of scratch as a cumulative histogram.
// Pipeline: address -> rdata (1 cycle) -> registered write (1 cycle).
// Scratch words not flagged in the captured mask contribute zero.
module histogram_readout #(
    parameter int NUM_WORDS = histogram_pkg::NUM_WORDS,
    parameter int BIN_W     = histogram_pkg::BIN_W,
    parameter int ADDR_W    = 16
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [NUM_WORDS-1:0]                        bin_valid_mask,
    output logic [ADDR_W-1:0]                           scratch_memory_address_pointer0,
    input  logic [histogram_pkg::BINS_PER_WORD*BIN_W-1:0] scratch_memory_rdata0,
    output logic                                        output_memory_write_enable,
    output logic [ADDR_W-1:0]                           output_memory_address,
    output logic [histogram_pkg::BINS_PER_WORD*BIN_W-1:0] output_memory_wdata,
    output logic                                        busy,
    output logic                                        done,
    output logic [BIN_W-1:0]                            total_count
);
    import histogram_pkg::*;

    localparam int NUM_LANES = BINS_PER_WORD;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int DATA_W    = NUM_LANES * BIN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e                        state;
    logic [IDX_W-1:0]              rd_idx;    // address being presented
    logic [IDX_W-1:0]              idx_q;     // word index paired with rdata
    logic [IDX_W-1:0]              wr_idx;    // word index of the registered write
    logic [1:0]                    vld_pipe;  // [0] rdata valid, [1] write valid
    logic [NUM_WORDS-1:0]          mask_q;
    logic [BIN_W-1:0]              acc;
    logic [BIN_W-1:0]              acc_next;
    logic [NUM_LANES-1:0][BIN_W-1:0] lane_bins;
    logic [NUM_LANES-1:0][BIN_W-1:0] cum_bins;
    logic [DATA_W-1:0]             wdata_next;
    logic [DATA_W-1:0]             wdata_q;
    logic                          word_valid;
    logic                          last_word;
    logic                          accept;

    assign accept     = (state == ST_IDLE) && start;
    assign word_valid = mask_q[idx_q];
    assign last_word  = vld_pipe[0] && (idx_q == LAST_IDX);

    // Unpack lanes (gating unwritten words to zero) and repack the sums
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        localparam int LSB = lane_lsb(j, BIN_W);
        assign lane_bins[j]              = word_valid ? scratch_memory_rdata0[LSB +: BIN_W] : '0;
        assign wdata_next[LSB +: BIN_W]  = cum_bins[j];
    end

    histogram_prefix_adder #(
        .NUM_LANES (NUM_LANES),
        .BIN_W     (BIN_W)
    ) u_prefix (
        .acc       (acc),
        .lane_bins (lane_bins),
        .cum_bins  (cum_bins),
        .acc_next  (acc_next)
    );

    // Control FSM: accept start, walk read addresses, finish on the last write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            rd_idx      <= '0;
            mask_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            total_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        rd_idx <= '0;
                        mask_q <= bin_valid_mask;
                        busy   <= 1'b1;
                    end else if (done) begin
                        // busy spans through the done cycle, then drops
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_idx == LAST_IDX) state  <= ST_DRAIN;
                    else                    rd_idx <= rd_idx + 1'b1;
                end
                ST_DRAIN: begin
                    if (last_word) begin
                        done        <= 1'b1;
                        total_count <= acc_next;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data pipeline: pair index with rdata, accumulate, register the write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            idx_q    <= '0;
            wr_idx   <= '0;
            wdata_q  <= '0;
            acc      <= '0;
        end else begin
            vld_pipe[0] <= (state == ST_RUN);
            vld_pipe[1] <= vld_pipe[0];
            idx_q       <= rd_idx;
            if (accept) begin
                acc <= '0;
            end else if (vld_pipe[0]) begin
                acc <= acc_next;
            end
            if (vld_pipe[0]) begin
                wr_idx  <= idx_q;
                wdata_q <= wdata_next;
            end
        end
    end

    assign scratch_memory_address_pointer0 = ADDR_W'(rd_idx);
    assign output_memory_write_enable      = vld_pipe[1];
    assign output_memory_address           = ADDR_W'(wr_idx);
    assign output_memory_wdata             = wdata_q;

endmodule

// File: tb/tb_histogram_readout.sv
// Directed + randomized bench for histogram_readout with a bin-level CDF model.
module tb_histogram_readout;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  bin_valid_mask = '0;
    logic [15:0]  scratch_addr;
    logic [127:0] scratch_rdata = '0;
    logic         wen;
    logic [15:0]  waddr;
    logic [127:0] wdata;
    logic         busy;
    logic         done;
    logic [31:0]  total_count;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [127:0] scr [64];
    logic [127:0] expw[64];
    logic [127:0] got [64];
    logic [31:0]  exp_total;

    histogram_readout dut (
        .clock                           (clock),
        .reset                           (reset),
        .start                           (start),
        .bin_valid_mask                  (bin_valid_mask),
        .scratch_memory_address_pointer0 (scratch_addr),
        .scratch_memory_rdata0           (scratch_rdata),
        .output_memory_write_enable      (wen),
        .output_memory_address           (waddr),
        .output_memory_wdata             (wdata),
        .busy                            (busy),
        .done                            (done),
        .total_count                     (total_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // Synchronous-read scratch RAM: data valid the cycle after the address
    always @(posedge clock) scratch_rdata <= scr[scratch_addr[5:0]];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: walk all 256 bins in order, keep a wrapping running sum
    task automatic build_exp(input logic [63:0] m);
        logic [31:0] running;
        logic [31:0] v;
        running = '0;
        for (int b = 0; b < 256; b++) begin
            int k, j;
            k = b / 4;
            j = b % 4;
            v = m[k] ? scr[k][(3 - j) * 32 +: 32] : 32'd0;
            running = running + v;
            expw[k][(3 - j) * 32 +: 32] = running;
        end
        exp_total = running;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) scr[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One pass: optional extra start at E<mid_at>, optional back-to-back chaining
    task automatic do_pass(input string name, input logic [63:0] m, input int mid_at,
                           input bit chain_in, input bit chain_out);
        int  start_cyc, n, first_wr, done_c;
        bit  order_ok, got_done, done_with_last;
        if (!chain_in) begin
            @(negedge clock);
            bin_valid_mask = m;
            start = 1'b1;
        end
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        bin_valid_mask = {$urandom, $urandom};
        chk({name, "_busy_on"}, 128'(busy), 128'(1));
        for (int k = 0; k < 64; k++) got[k] = {128{1'bx}};
        n = 0; first_wr = -1; done_c = -1;
        order_ok = 1'b1; got_done = 1'b0; done_with_last = 1'b0;
        for (int t = 0; t < 200 && !got_done; t++) begin
            @(negedge clock);
            start = (mid_at > 0) && (cyc == start_cyc + mid_at - 1);
            if (wen) begin
                if (first_wr < 0) first_wr = cyc - start_cyc;
                if (waddr != 16'(n)) order_ok = 1'b0;
                got[waddr[5:0]] = wdata;
                n++;
            end
            if (done) begin
                got_done = 1'b1;
                done_c = cyc - start_cyc;
                done_with_last = wen && (waddr == 16'd63);
            end
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, 128'(done_c), 128'(65));
        chk({name, "_first_write"}, 128'(first_wr), 128'(2));
        chk({name, "_nwrites"}, 128'(n), 128'(64));
        chk({name, "_order"}, 128'(order_ok), 128'(1));
        chk({name, "_done_last"}, 128'(done_with_last), 128'(1));
        chk({name, "_total"}, 128'(total_count), 128'(exp_total));
        for (int k = 0; k < 64; k++) chk($sformatf("%s_w%0d", name, k), got[k], expw[k]);
        if (chain_out) begin
            bin_valid_mask = m;
            start = 1'b1;
        end else begin
            @(negedge clock);
            chk({name, "_busy_off"}, 128'(busy), 128'(0));
            chk({name, "_wen_off"}, 128'(wen), 128'(0));
            chk({name, "_total_hold"}, 128'(total_count), 128'(exp_total));
        end
    endtask

    initial begin
        logic [63:0] m;
        int sc, wcount;

        for (int k = 0; k < 64; k++) scr[k] = '0;
        repeat (3) @(negedge clock);
        chk("rst_wen", 128'(wen), 128'(0));
        chk("rst_waddr", 128'(waddr), 128'(0));
        chk("rst_wdata", wdata, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_total", 128'(total_count), 128'(0));
        chk("rst_raddr", 128'(scratch_addr), 128'(0));
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Unwritten words must never leak, even all-ones garbage
        for (int k = 0; k < 64; k++) scr[k] = '1;
        build_exp(64'd0);
        do_pass("zero_mask", 64'd0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 64; k++) scr[k] = {32'd1, 32'd1, 32'd1, 32'd1};
        build_exp('1);
        do_pass("ones", '1, 0, 1'b0, 1'b0);

        fill_random();
        scr[5] = {32'd1, 32'd2, 32'd3, 32'd4};
        build_exp(64'd1 << 5);
        do_pass("word5", 64'd1 << 5, 0, 1'b0, 1'b0);

        for (int k = 0; k < 64; k++) scr[k] = '0;
        scr[0] = {32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
        build_exp('1);
        do_pass("wrap", '1, 0, 1'b0, 1'b0);

        fill_random();
        m = {$urandom, $urandom};
        build_exp(m);
        do_pass("mid_start", m, 10, 1'b0, 1'b0);

        // Back-to-back: start on the edge where done deasserts
        fill_random();
        m = {$urandom, $urandom};
        build_exp(m);
        do_pass("chain_a", m, 0, 1'b0, 1'b1);
        do_pass("chain_b", m, 0, 1'b1, 1'b0);

        // Reset in the middle of a pass
        fill_random();
        m = {$urandom, $urandom};
        @(negedge clock);
        bin_valid_mask = m;
        start = 1'b1;
        @(posedge clock);
        #1;
        sc = cyc;
        start = 1'b0;
        for (int t = 0; t < 100 && cyc < sc + 20; t++) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_wen", 128'(wen), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_wdata", wdata, 128'(0));
        chk("midrst_raddr", 128'(scratch_addr), 128'(0));
        wcount = 0;
        repeat (4) begin
            @(negedge clock);
            if (wen) wcount++;
        end
        reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (wen) wcount++;
        end
        chk("midrst_no_writes", 128'(wcount), 128'(0));
        chk("midrst_idle", 128'(busy), 128'(0));
        fill_random();
        m = {$urandom, $urandom};
        build_exp(m);
        do_pass("after_rst", m, 0, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            m = (r == 0) ? '1 : {$urandom, $urandom};
            build_exp(m);
            do_pass($sformatf("rand%0d", r), m, 0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/histogram_readout.md
# histogram_readout

Reads the finished 256-bin histogram back out of scratch memory after the histogram data path has filled it. Converts the bins into a cumulative histogram (CDF) and streams it word by word into an output memory for the equalization stage. Scratch words that the data path never wrote are treated as zero, so uninitialised RAM contents never reach the output. It is the reader-side counterpart of the scratch-memory write path and shares its 128-bit, 4-bins-per-word layout.

## Interface
- NUM_WORDS, 64, scratch words read per pass (256 bins / 4)
- BIN_W, 32, width of one bin and of the running sum
- ADDR_W, 16, memory address width

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- start  in  1  one-cycle request to begin a pass; honoured only in IDLE
- bin_valid_mask  in  64  bit k = 1 means scratch word k was written; sampled at the accepted start
- scratch_memory_address_pointer0  out  ADDR_W  scratch read address
- scratch_memory_rdata0  in  128  scratch read data, valid the cycle after its address
- output_memory_write_enable  out  1  write strobe, one word per cycle
- output_memory_address  out  ADDR_W  output word index, 0..63
- output_memory_wdata  out  128  four cumulative bins
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse on the last write
- total_count  out  BIN_W  final running sum, held until the next accepted start

## Operation
- Bin mapping: word k holds bins 4k..4k+3. Bin 4k+0 is in [127:96], 4k+1 in [95:64], 4k+2 in [63:32], 4k+3 in [31:0]. The output uses the same lane order.
- Masking: lane data = mask_q[k] ? rdata lane : 0, where mask_q is bin_valid_mask captured at start.
- Prefix sum, all modulo 2^BIN_W with no saturation:
  - c0 = acc + b0, c1 = c0 + b1, c2 = c1 + b2, c3 = c2 + b3.
  - acc <= c3 after each word.
  - acc is cleared at start.
- FSM:
  - IDLE: on start, clear acc, set read address to 0, capture the mask, set busy = 1, go to RUN.
  - RUN: increment the read address each cycle. After presenting address 63, go to DRAIN.
  - DRAIN: wait for the word-63 write, pulse done, load total_count, go to IDLE.
- A read-valid flag and the word index are delayed one cycle to pair each index with its rdata. Writes are registered one cycle after rdata.
- start while busy is ignored. bin_valid_mask changes during a pass are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; acc 0; mask_q 0.
- Reset asserted mid-pass:
  - outputs clear immediately and no further writes occur;
  - after release, the block idles until a new start.
- Pass timeline:
  - edge E0 samples start;
  - address k is presented after edge E(k);
  - the word-k write is visible after edge E(k+2) (2-cycle latency);
  - writes are back-to-back with no bubbles, 64 strobes in total;
  - the last write and done coincide after E65;
  - busy falls at E66.
- start on the same edge as done's deassertion (E66) is accepted.
- output_memory_write_enable is high only for the 64 data cycles of a pass.

## Structure
- Package histogram_pkg:
  - NUM_WORDS, BINS_PER_WORD (4), BIN_W;
  - lane bit-position constants;
  - FSM state enum (IDLE, RUN, DRAIN).
  - The histogram data path uses the same lane constants.
- Sub-module histogram_prefix_adder: purely combinational. Takes acc plus four masked lanes; produces c0..c3 and the next acc.

## Test plan
- All-zero mask, rdata = all-ones → 64 writes of 0, total_count = 0, done after E65.
- Full mask, every bin = 1 → word k wdata = {4k+1, 4k+2, 4k+3, 4k+4}, total_count = 256.
- Only word 5 valid, bins {1,2,3,4}:
  - words 0–4 write 0;
  - words 5–63 write {1,3,6,10} then {10,10,10,10};
  - total_count = 10.
- Full mask, bin 0 = 0xFFFF_FFFF, bin 1 = 2, others 0 → word 0 = {FFFF_FFFF, 1, 1, 1}, total_count = 1 (wrap).
- start pulsed again at E10 → ignored; exactly 64 writes, addresses 0..63 in order.
- reset asserted at E20 → write_enable drops asynchronously; no writes until the next start; a following pass produces correct, fresh output.
